// File: rtl/busy_done_mem_slave.sv
// Memory-side responder for the MEM_* busy/done bus: accepts one RE/WE request,
// holds MEM_BUSY for LATENCY cycles, pulses MEM_DONE, and serves an internal word array.
module busy_done_mem_slave #(
    parameter int WA         = 32,
    parameter int WD         = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter int ADDR_SHIFT = 5,
    parameter int LATENCY    = 3
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic [WA-1:0] MEM_A,
    input  logic          MEM_RE,
    input  logic          MEM_WE,
    input  logic [WD-1:0] MEM_D,
    output logic [WD-1:0] MEM_Q,
    output logic          MEM_BUSY,
    output logic          MEM_DONE,
    output logic          ERR,
    output logic [31:0]   RD_CNT,
    output logic [31:0]   WR_CNT
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  armed_q, armed_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic                  oor_q, oor_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [WD-1:0]         wdata_q, wdata_d;
    logic [WD-1:0]         q_q, q_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [31:0]           rd_cnt_q, rd_cnt_d;
    logic [31:0]           wr_cnt_q, wr_cnt_d;

    logic [WD-1:0]         mem_arr [DEPTH];
    logic [WA-1:0]         idx_full;
    logic                  req;
    logic                  accept;
    logic                  req_oor;
    logic                  commit;

    assign idx_full = MEM_A >> ADDR_SHIFT;
    assign req_oor  = |(idx_full >> DEPTH_LOG2);
    assign req      = MEM_RE | MEM_WE;
    assign accept   = (state_q == S_IDLE) && armed_q && req;

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        cnt_d    = cnt_q;
        op_wr_d  = op_wr_q;
        oor_d    = oor_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        q_d      = q_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;

        // A strobe held across the whole handshake must drop before it can re-issue.
        if (accept) begin
            armed_d = 1'b0;
        end else if (!req) begin
            armed_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_wr_d = MEM_WE;
                    idx_d   = idx_full[DEPTH_LOG2-1:0];
                    oor_d   = req_oor;
                    wdata_d = MEM_D;
                    cnt_d   = 8'(LATENCY - 1);
                    busy_d  = 1'b1;
                    state_d = S_ACTIVE;
                    if ((MEM_RE && MEM_WE) || req_oor) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (!op_wr_q) begin
                        q_d = oor_q ? '0 : mem_arr[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (op_wr_q) begin
                    wr_cnt_d = wr_cnt_q + 32'd1;
                end else begin
                    rd_cnt_d = rd_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q  <= S_IDLE;
            armed_q  <= 1'b1;
            cnt_q    <= '0;
            op_wr_q  <= 1'b0;
            oor_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            q_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            oor_q    <= oor_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            q_q      <= q_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Writes land only in the DONE cycle; an async reset leaves IDLE, so an aborted write never commits.
    assign commit = (state_q == S_DONE) && op_wr_q && !oor_q;

    always_ff @(posedge CLK) begin
        if (commit) begin
            mem_arr[idx_q] <= wdata_q;
        end
    end

    assign MEM_Q    = q_q;
    assign MEM_BUSY = busy_q;
    assign MEM_DONE = done_q;
    assign ERR      = err_q;
    assign RD_CNT   = rd_cnt_q;
    assign WR_CNT   = wr_cnt_q;

endmodule

// File: tb/tb_busy_done_mem_slave.sv
// Bench for busy_done_mem_slave: vector table plus hand-written sequences for
// held strobes, mid-operation reset and a vector-add style access pattern.
module tb_busy_done_mem_slave;

    localparam int LAT = 3;

    logic        CLK = 1'b0;
    logic        RST_X = 1'b1;

    logic [31:0] mem_a = '0, mem_d = '0;
    logic        mem_re = 1'b0, mem_we = 1'b0;
    logic [31:0] mem_q, rd_cnt, wr_cnt;
    logic        busy, done, err;

    logic [31:0] a1 = '0, d1 = '0;
    logic        re1 = 1'b0, we1 = 1'b0;
    logic [31:0] q1, rdc1, wrc1;
    logic        busy1, done1, err1;

    busy_done_mem_slave #(.LATENCY(LAT)) dut (
        .CLK(CLK), .RST_X(RST_X), .MEM_A(mem_a), .MEM_RE(mem_re), .MEM_WE(mem_we),
        .MEM_D(mem_d), .MEM_Q(mem_q), .MEM_BUSY(busy), .MEM_DONE(done), .ERR(err),
        .RD_CNT(rd_cnt), .WR_CNT(wr_cnt)
    );

    busy_done_mem_slave #(.LATENCY(1)) dut1 (
        .CLK(CLK), .RST_X(RST_X), .MEM_A(a1), .MEM_RE(re1), .MEM_WE(we1),
        .MEM_D(d1), .MEM_Q(q1), .MEM_BUSY(busy1), .MEM_DONE(done1), .ERR(err1),
        .RD_CNT(rdc1), .WR_CNT(wrc1)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          we;
        bit          re;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_q;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        bit          err;
    } exp_t;

    vec_t        tbl [14];
    exp_t        sb [$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] rd_exp = '0, wr_exp = '0;
    logic [31:0] last_q = '0;
    bit          err_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_q, input bit exp_err);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge CLK);
        mem_we = we; mem_re = re; mem_a = a; mem_d = d;
        e.q = exp_q; e.err = exp_err;
        sb.push_back(e);
        if (we) wr_exp++;
        else if (re) rd_exp++;
        n = 0; seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge CLK);
            n++;
            mem_we = 1'b0; mem_re = 1'b0;
            if (n == 1) chk("busy_after_accept", 32'(busy), 32'd1);
            if (done) seen = 1'b1;
        end
        chk("done_latency", seen ? 32'(n) : 32'hFFFF_FFFF, 32'(LAT + 1));
        e = sb.pop_front();
        chk("q_at_done", mem_q, e.q);
        chk("err_at_done", 32'(err), 32'(e.err));
        @(negedge CLK);
        chk("done_drop", 32'(done), 32'd0);
        chk("busy_drop", 32'(busy), 32'd0);
        chk("rd_cnt", rd_cnt, rd_exp);
        chk("wr_cnt", wr_cnt, wr_exp);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        access(1'b0, 1'b1, a, 32'h0, exp, err_exp);
        last_q = exp;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        access(1'b1, 1'b0, a, d, last_q, err_exp);
    endtask

    initial begin
        int          ndone;
        bit          seen;
        logic [31:0] av [4];
        logic [31:0] bv [4];

        tbl[0]  = '{1'b1, 1'b0, 32'h40,          32'hDEAD,      32'h0,         1'b0};
        tbl[1]  = '{1'b0, 1'b1, 32'h40,          32'h0,         32'hDEAD,      1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h80,          32'h1234_5678, 32'hDEAD,      1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h1FFE0,       32'hA5A5_A5A5, 32'hDEAD,      1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'h1FFE0,       32'h0,         32'hA5A5_A5A5, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'h80,          32'h0,         32'h1234_5678, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,           32'h1111,      32'h1234_5678, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'h0,           32'h0,         32'h1111,      1'b0};
        tbl[8]  = '{1'b1, 1'b1, 32'h20,          32'h5,         32'h1111,      1'b1};
        tbl[9]  = '{1'b0, 1'b1, 32'h20,          32'h0,         32'h5,         1'b1};
        tbl[10] = '{1'b1, 1'b0, 32'h1000 << 5,   32'h1,         32'h5,         1'b1};
        tbl[11] = '{1'b0, 1'b1, 32'h0,           32'h0,         32'h1111,      1'b1};
        tbl[12] = '{1'b0, 1'b1, 32'h1000 << 5,   32'h0,         32'h0,         1'b1};
        tbl[13] = '{1'b0, 1'b1, 32'h40,          32'h0,         32'hDEAD,      1'b1};

        #2 RST_X = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_q", mem_q, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd_cnt", rd_cnt, 32'd0);
        chk("rst_wr_cnt", wr_cnt, 32'd0);
        RST_X = 1'b1;

        // Held read strobe with single-cycle latency
        @(negedge CLK);
        we1 = 1'b1; a1 = 32'h40; d1 = 32'hBEEF;
        @(negedge CLK);
        we1 = 1'b0;
        repeat (3) @(negedge CLK);
        chk("l1_wr_cnt", wrc1, 32'd1);
        ndone = 0;
        re1 = 1'b1; a1 = 32'h40;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (done1) begin
                ndone++;
                chk("l1_q", q1, 32'hBEEF);
            end
            if (k == 6) re1 = 1'b0;
        end
        chk("l1_done_pulses", 32'(ndone), 32'd1);
        chk("l1_rd_cnt", rdc1, 32'd1);
        re1 = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            @(negedge CLK);
            re1 = 1'b0;
            if (done1) seen = 1'b1;
        end
        chk("l1_second_done", 32'(seen), 32'd1);
        repeat (2) @(negedge CLK);
        chk("l1_rd_cnt2", rdc1, 32'd2);

        // Table-driven single accesses on the LATENCY=3 instance
        for (int i = 0; i < 14; i++) begin
            err_exp = tbl[i].exp_err;
            access(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].d, tbl[i].exp_q, tbl[i].exp_err);
            last_q = tbl[i].exp_q;
        end

        // Reset in the middle of a write
        wr(32'h60, 32'h9);
        @(negedge CLK);
        mem_we = 1'b1; mem_a = 32'h60; mem_d = 32'h7;
        @(negedge CLK);
        mem_we = 1'b0;
        chk("abort_busy_before", 32'(busy), 32'd1);
        @(negedge CLK);
        #2 RST_X = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge CLK);
        RST_X = 1'b1;
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_rd_cnt", rd_cnt, 32'd0);
        chk("abort_wr_cnt", wr_cnt, 32'd0);
        rd_exp = '0; wr_exp = '0; last_q = '0; err_exp = 1'b0;
        rd(32'h60, 32'h9);

        // Vector-add access pattern: C[i] = A[i] + B[i], i = 0..3
        for (int i = 0; i < 4; i++) begin
            av[i] = 32'h100 + 32'(i * 7);
            bv[i] = 32'hFFFF_FFF0 + 32'(i * 9);
            wr(32'h1000 + 32'(i * 32), av[i]);
            wr(32'h2000 + 32'(i * 32), bv[i]);
        end
        for (int i = 0; i < 4; i++) begin
            rd(32'h1000 + 32'(i * 32), av[i]);
            rd(32'h2000 + 32'(i * 32), bv[i]);
            wr(32'h3000 + 32'(i * 32), av[i] + bv[i]);
        end
        for (int i = 0; i < 4; i++) begin
            rd(32'h3000 + 32'(i * 32), av[i] + bv[i]);
        end
        chk("vadd_no_err", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
